// File: rtl/stamp_writer_pkg.sv
// Frame geometry shared with the colour-tracking block, plus the stamp FSM encoding.
package stamp_writer_pkg;

    localparam int unsigned FRAME_W    = 640;
    localparam int unsigned FRAME_H    = 480;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned STAMP_HALF = 4;
    localparam int unsigned COORD_W    = 16;

    localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stamp_addr_gen.sv
// Walks the clipped stamp window row-major; row_base accumulates by FRAME_W so the loop needs no multiplier.
module stamp_addr_gen
    import stamp_writer_pkg::*;
#(
    parameter int unsigned FRAME_W = stamp_writer_pkg::FRAME_W,
    parameter int unsigned ADDR_W  = stamp_writer_pkg::ADDR_W,
    parameter int unsigned COORD_W = stamp_writer_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] y1,
    input  logic [ADDR_W-1:0]  base0,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col_lo;
    logic [COORD_W-1:0] col_hi;
    logic [COORD_W-1:0] row_hi;
    logic [ADDR_W-1:0]  row_base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col      <= '0;
            row      <= '0;
            col_lo   <= '0;
            col_hi   <= '0;
            row_hi   <= '0;
            row_base <= '0;
        end else if (load) begin
            col      <= x0;
            row      <= y0;
            col_lo   <= x0;
            col_hi   <= x1;
            row_hi   <= y1;
            row_base <= base0;
        end else if (advance) begin
            if (col < col_hi) begin
                col <= col + 1'b1;
            end else if (row < row_hi) begin
                col      <= col_lo;
                row      <= row + 1'b1;
                row_base <= row_base + ADDR_W'(FRAME_W);
            end
        end
    end

    assign addr = row_base + ADDR_W'(col);
    assign last = (col >= col_hi) && (row >= row_hi);

endmodule

// File: rtl/stamp_writer.sv
// Draws a clipped square stamp of one colour around the tracked position via a valid/ready pixel-write port.
//
//   state | meaning
//   IDLE  | waiting for start; inputs latched on start
//   SETUP | bounds check and window clipping, address generator loaded
//   WRITE | one pixel write per handshake, row-major
//   DONE  | one-cycle done pulse, skipped qualifies it
module stamp_writer
    import stamp_writer_pkg::*;
#(
    parameter int unsigned FRAME_W    = stamp_writer_pkg::FRAME_W,
    parameter int unsigned FRAME_H    = stamp_writer_pkg::FRAME_H,
    parameter int unsigned STAMP_HALF = stamp_writer_pkg::STAMP_HALF,
    parameter int unsigned ADDR_W     = stamp_writer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       x_pos,
    input  logic [31:0]       y_pos,
    input  logic [31:0]       stamp_color,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              skipped
);

    localparam logic [32:0] FW33   = 33'(FRAME_W);
    localparam logic [32:0] FH33   = 33'(FRAME_H);
    localparam logic [32:0] HALF33 = 33'(STAMP_HALF);

    state_t state;
    state_t state_nxt;

    logic [31:0]        x_lat;
    logic [31:0]        y_lat;
    logic [31:0]        color_lat;
    logic               skip_flag;

    logic [32:0]        x_ext;
    logic [32:0]        y_ext;
    logic [32:0]        x_hi;
    logic [32:0]        y_hi;
    logic               out_of_frame;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
    logic [ADDR_W-1:0]  base0;

    logic               load;
    logic               hs;
    logic               last_pix;
    logic [ADDR_W-1:0]  gen_addr;

    // Widened by one bit so x + STAMP_HALF cannot wrap before the compare.
    always_comb begin
        x_ext        = {1'b0, x_lat};
        y_ext        = {1'b0, y_lat};
        x_hi         = x_ext + HALF33;
        y_hi         = y_ext + HALF33;
        out_of_frame = (x_ext >= FW33) || (y_ext >= FH33);
        x0 = (x_ext < HALF33)     ? '0 : COORD_W'(x_ext - HALF33);
        y0 = (y_ext < HALF33)     ? '0 : COORD_W'(y_ext - HALF33);
        x1 = (x_hi > FW33 - 33'd1) ? COORD_W'(FRAME_W - 1) : COORD_W'(x_hi);
        y1 = (y_hi > FH33 - 33'd1) ? COORD_W'(FRAME_H - 1) : COORD_W'(y_hi);
        base0 = ADDR_W'(32'(y0) * FRAME_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_lat     <= '0;
            y_lat     <= '0;
            color_lat <= '0;
        end else if (state == ST_IDLE && start) begin
            x_lat     <= x_pos;
            y_lat     <= y_pos;
            color_lat <= stamp_color;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_flag <= 1'b0;
        end else if (state == ST_SETUP) begin
            skip_flag <= out_of_frame;
        end else if (state == ST_DONE) begin
            skip_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = out_of_frame ? ST_DONE : ST_WRITE;
            ST_WRITE: if (hs && last_pix) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_valid = (state == ST_WRITE);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        skipped  = (state == ST_DONE) && skip_flag;
        load     = (state == ST_SETUP) && !out_of_frame;
    end

    assign hs      = wr_valid && wr_ready;
    assign wr_addr = gen_addr;
    assign wr_data = color_lat;

    stamp_addr_gen #(
        .FRAME_W (FRAME_W),
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .advance (hs),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .base0   (base0),
        .addr    (gen_addr),
        .last    (last_pix)
    );

endmodule

// File: tb/tb_stamp_writer.sv
// Directed and randomized stamps checked against a window-enumerating reference model.
module tb_stamp_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x_pos = '0;
    logic [31:0] y_pos = '0;
    logic [31:0] stamp_color = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [18:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        skipped;

    int passed = 0;
    int total  = 0;
    int exp_q[$];

    stamp_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .stamp_color (stamp_color),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .skipped     (skipped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every in-frame pixel within STAMP_HALF of the centre, row-major.
    task automatic build_expected(input logic [31:0] x, input logic [31:0] y);
        longint xl, yl;
        exp_q.delete();
        xl = longint'(x);
        yl = longint'(y);
        if (xl >= 640 || yl >= 480) return;
        for (longint r = yl - 4; r <= yl + 4; r++)
            for (longint c = xl - 4; c <= xl + 4; c++)
                if (r >= 0 && r < 480 && c >= 0 && c < 640)
                    exp_q.push_back(int'(r * 640 + c));
    endtask

    task automatic run_stamp(input logic [31:0] x, input logic [31:0] y,
                             input bit bp, input bit poke, input int abort_at);
        logic [31:0] color;
        int idx, cycles, max_addr;
        bit prev_stall, saw_done;
        logic [18:0] prev_addr;
        logic [31:0] prev_data;

        build_expected(x, y);
        color       = $urandom;
        start       = 1'b1;
        x_pos       = x;
        y_pos       = y;
        stamp_color = color;
        wr_ready    = 1'b1;
        tick();
        start       = 1'b0;
        x_pos       = $urandom;
        y_pos       = $urandom;
        stamp_color = $urandom;
        check("setup_busy", busy, 1);
        check("setup_valid", wr_valid, 0);
        tick();

        if (exp_q.size() == 0) begin
            check("skip_done", done, 1);
            check("skip_skipped", skipped, 1);
            check("skip_valid", wr_valid, 0);
            tick();
            check("skip_idle_busy", busy, 0);
            check("skip_idle_done", done, 0);
            return;
        end

        check("first_valid", wr_valid, 1);
        idx = 0; cycles = 0; max_addr = 0;
        prev_stall = 0; saw_done = 0;
        prev_addr = '0; prev_data = '0;
        while (cycles < 3000) begin
            if (done) begin
                saw_done = 1;
                break;
            end
            wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                x_pos = $urandom_range(0, 639);
                y_pos = $urandom_range(0, 479);
            end
            if (prev_stall) begin
                check("stall_addr", wr_addr, prev_addr);
                check("stall_data", wr_data, prev_data);
            end
            if (wr_valid && wr_ready) begin
                if (idx < exp_q.size())
                    check("write_addr", wr_addr, exp_q[idx]);
                else
                    check("extra_write", idx, exp_q.size());
                check("write_data", wr_data, color);
                if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
                idx++;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            tick();
            cycles++;
            if (abort_at != 0 && idx == abort_at) begin
                start = 1'b0;
                #2 reset_n = 1'b0;
                #1;
                check("abort_valid", wr_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                repeat (3) begin
                    tick();
                    check("abort_no_done", done, 0);
                end
                reset_n = 1'b1;
                tick();
                check("abort_idle", busy, 0);
                return;
            end
        end
        start = 1'b0;
        check("done_seen", saw_done, 1);
        if (!saw_done) return;
        check("done_skipped", skipped, 0);
        check("beats", idx, exp_q.size());
        check("addr_in_frame", max_addr < 307200, 1);
        if (!bp) check("consecutive", cycles, exp_q.size());
        // A start in the DONE cycle must not launch another stamp.
        start = poke;
        tick();
        start = 1'b0;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        tick();
        check("post_busy2", busy, 0);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_valid", wr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_skipped", skipped, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        reset_n = 1'b1;
        tick();

        run_stamp(32'd100, 32'd50, 0, 0, 0);
        run_stamp(32'd0, 32'd0, 0, 0, 0);
        run_stamp(32'd639, 32'd479, 0, 0, 0);
        run_stamp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        run_stamp(32'd640, 32'd10, 0, 0, 0);
        run_stamp(32'd10, 32'd480, 0, 0, 0);
        run_stamp(32'd100, 32'd50, 1, 0, 0);
        run_stamp(32'd100, 32'd50, 0, 1, 0);
        run_stamp(32'd100, 32'd50, 1, 1, 0);
        run_stamp(32'd100, 32'd50, 0, 0, 10);
        run_stamp(32'd100, 32'd50, 0, 0, 0);
        run_stamp(32'd2, 32'd477, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            run_stamp($urandom_range(0, 660), $urandom_range(0, 500), 1, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
